// File: rtl/blood_fx_pkg.sv
// Shared constants, slot state and slot record for the blood-splatter effect controller.
package blood_fx_pkg;

    localparam int unsigned SPRITE_DIM  = 64;
    localparam logic [11:0] TRANSPARENT = 12'h000;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_PLAY = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] frame;
        logic [7:0] hold;
        logic       newest;
    } slot_t;

    // True when an 11-bit two's-complement offset lands inside the sprite box.
    function automatic logic in_sprite(input logic [10:0] d);
        return !d[10] && (d[9:0] < 10'(SPRITE_DIM));
    endfunction

endpackage

// File: rtl/blood_fx_if.sv
// Request, scan-position, ROM and overlay signals between the renderer and the blood effect controller.
// master = renderer/ROM side, slave = controller.
interface blood_fx_if;

    logic        frame_tick;
    logic [1:0]  hit_req;
    logic [9:0]  hit_x0;
    logic [9:0]  hit_y0;
    logic [9:0]  hit_x1;
    logic [9:0]  hit_y1;
    logic [1:0]  hit_ack;
    logic [1:0]  slot_busy;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [5:0]  rom_row;
    logic [5:0]  rom_col;
    logic [3:0]  rom_frame;
    logic [11:0] rom_data;
    logic        blood_on;
    logic [11:0] blood_rgb;

    modport master (
        output frame_tick, hit_req, hit_x0, hit_y0, hit_x1, hit_y1,
        output pixel_x, pixel_y, rom_data,
        input  hit_ack, slot_busy, rom_row, rom_col, rom_frame, blood_on, blood_rgb
    );

    modport slave (
        input  frame_tick, hit_req, hit_x0, hit_y0, hit_x1, hit_y1,
        input  pixel_x, pixel_y, rom_data,
        output hit_ack, slot_busy, rom_row, rom_col, rom_frame, blood_on, blood_rgb
    );

endinterface

// File: rtl/blood_fx_slot.sv
// One animation slot: IDLE/PLAY state, frame/hold counters advanced on frame_tick, and the sprite hit test.
// State updates on the edge after grant/tick; hit/row/col are combinational from the current pixel.
module blood_fx_slot
    import blood_fx_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 12,
    parameter int unsigned FRAME_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       grant_i,
    input  logic       clr_newest_i,
    input  logic       tick_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       busy_o,
    output logic       newest_o,
    output logic       hit_o,
    output logic [3:0] frame_o,
    output logic [5:0] row_o,
    output logic [5:0] col_o
);

    localparam logic [0:0] ST_IDLE    = 1'(SLOT_IDLE);
    localparam logic [0:0] ST_PLAY    = 1'(SLOT_PLAY);
    localparam logic [7:0] HOLD_LAST  = 8'(FRAME_HOLD - 1);
    localparam logic [3:0] FRAME_LAST = 4'(NUM_FRAMES - 1);

    logic [0:0] state_q, state_d;
    slot_t      slot_q, slot_d;
    logic [10:0] dx, dy;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        // A grant restarts the animation, so a coincident tick is dropped.
        if (grant_i) begin
            state_d       = ST_PLAY;
            slot_d.x      = x_i;
            slot_d.y      = y_i;
            slot_d.frame  = 4'd0;
            slot_d.hold   = 8'd0;
            slot_d.newest = 1'b1;
        end else if (tick_i && (state_q == ST_PLAY)) begin
            if (slot_q.hold < HOLD_LAST) begin
                slot_d.hold = slot_q.hold + 8'd1;
            end else begin
                slot_d.hold = 8'd0;
                if (slot_q.frame == FRAME_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    slot_d.frame = slot_q.frame + 4'd1;
                end
            end
        end
        if (clr_newest_i) begin
            slot_d.newest = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Zero-extended subtraction keeps the sign in bit 10, so offsets never wrap.
    assign dx = {1'b0, pixel_x_i} - {1'b0, slot_q.x};
    assign dy = {1'b0, pixel_y_i} - {1'b0, slot_q.y};

    assign busy_o   = (state_q == ST_PLAY);
    assign newest_o = slot_q.newest;
    assign hit_o    = busy_o && in_sprite(dx) && in_sprite(dy);
    assign frame_o  = slot_q.frame;
    assign row_o    = dy[5:0];
    assign col_o    = dx[5:0];

endmodule

// File: rtl/blood_fx_ctrl.sv
// Blood effect controller: two-slot allocator with round-robin tie-break, newest-wins overlay and ROM pipeline.
// hit_ack combinational (0 cycles), ROM address +1, overlay pixel +3; no stalls, requesters hold hit_req until acked.
module blood_fx_ctrl
    import blood_fx_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 12,
    parameter int unsigned FRAME_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    blood_fx_if.slave  fx
);

    logic [1:0] busy;
    logic [1:0] free;
    logic [1:0] newest;
    logic [1:0] hit;
    logic [1:0] grant;
    logic [1:0] ack;
    logic [1:0] src;
    logic [1:0] clr_newest;
    logic       tgt;
    logic       rr_q, rr_d;
    logic       sel;
    logic [3:0] frame_s [2];
    logic [5:0] row_s   [2];
    logic [5:0] col_s   [2];

    logic [5:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [3:0]  frame_q, frame_d;
    logic        hit_d1_q, hit_d2_q;
    logic        on_q, on_d;
    logic [11:0] rgb_q, rgb_d;

    assign free = ~busy;
    assign tgt  = ~free[0];

    always_comb begin
        grant = 2'b00;
        ack   = 2'b00;
        src   = 2'b00;
        rr_d  = rr_q;
        case (fx.hit_req)
            2'b01, 2'b10: begin
                if (|free) begin
                    grant[tgt]         = 1'b1;
                    src[tgt]           = fx.hit_req[1];
                    ack[fx.hit_req[1]] = 1'b1;
                end
            end
            2'b11: begin
                if (&free) begin
                    grant = 2'b11;
                    src   = 2'b10;
                    ack   = 2'b11;
                end else if (|free) begin
                    grant[tgt] = 1'b1;
                    src[tgt]   = rr_q;
                    ack[rr_q]  = 1'b1;
                    rr_d       = ~rr_q;
                end
            end
            default: ;
        endcase
    end

    // On a double grant slot 1 ends up newest, so it is drawn on top.
    assign clr_newest = {grant[0] & ~grant[1], grant[1]};

    for (genvar j = 0; j < 2; j++) begin : g_slot
        blood_fx_slot #(
            .NUM_FRAMES (NUM_FRAMES),
            .FRAME_HOLD (FRAME_HOLD)
        ) u_slot (
            .clk          (clk),
            .rst          (reset),
            .grant_i      (grant[j]),
            .clr_newest_i (clr_newest[j]),
            .tick_i       (fx.frame_tick),
            .x_i          (src[j] ? fx.hit_x1 : fx.hit_x0),
            .y_i          (src[j] ? fx.hit_y1 : fx.hit_y0),
            .pixel_x_i    (fx.pixel_x),
            .pixel_y_i    (fx.pixel_y),
            .busy_o       (busy[j]),
            .newest_o     (newest[j]),
            .hit_o        (hit[j]),
            .frame_o      (frame_s[j]),
            .row_o        (row_s[j]),
            .col_o        (col_s[j])
        );
    end

    assign sel = hit[1] & ~(hit[0] & newest[0]);

    always_comb begin
        row_d   = 6'd0;
        col_d   = 6'd0;
        frame_d = 4'd0;
        if (|hit) begin
            row_d   = row_s[sel];
            col_d   = col_s[sel];
            frame_d = frame_s[sel];
        end
        on_d  = hit_d2_q && (fx.rom_data != TRANSPARENT);
        rgb_d = on_d ? fx.rom_data : 12'h000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q     <= 1'b0;
            row_q    <= 6'd0;
            col_q    <= 6'd0;
            frame_q  <= 4'd0;
            hit_d1_q <= 1'b0;
            hit_d2_q <= 1'b0;
            on_q     <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            rr_q     <= rr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            hit_d1_q <= |hit;
            hit_d2_q <= hit_d1_q;
            on_q     <= on_d;
            rgb_q    <= rgb_d;
        end
    end

    assign fx.hit_ack   = reset ? 2'b00 : ack;
    assign fx.slot_busy = busy;
    assign fx.rom_row   = row_q;
    assign fx.rom_col   = col_q;
    assign fx.rom_frame = frame_q;
    assign fx.blood_on  = on_q;
    assign fx.blood_rgb = rgb_q;

endmodule
